// File: rtl/serial2parallel_stream.sv
// Serial-to-parallel deserialiser: shifts in WIDTH data bits (plus optional parity)
// on bit_en strobes and presents each word on a valid/ready output register.
module serial2parallel_stream #(
   parameter  int WIDTH      = 8,
   parameter  int MSB_FIRST  = 0,
   parameter  int PARITY_EN  = 0,
   parameter  int PARITY_ODD = 0,
   localparam int CW         = $clog2(WIDTH + 2)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_en,
   input  logic             serial_start,
   input  logic             d,
   output logic [WIDTH-1:0] a,
   output logic             a_valid,
   input  logic             a_ready,
   output logic             end_conversion,
   output logic             parity_err,
   output logic             overrun,
   output logic             busy,
   output logic [CW-1:0]    bit_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt, word;
   logic [CW-1:0]    cnt_nxt;
   logic             complete, word_perr;

   function automatic logic [WIDTH-1:0] insert(input logic [WIDTH-1:0] cur, input logic bit_in);
      if (MSB_FIRST != 0) return {cur[WIDTH-2:0], bit_in};
      else                return {bit_in, cur[WIDTH-1:1]};
   endfunction

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = bit_count;
      complete  = 1'b0;
      word      = sr;
      word_perr = 1'b0;
      if (bit_en) begin
         if (serial_start) begin
            // Start from IDLE and restart mid-frame look the same: d is bit 0.
            state_nxt = SHIFT;
            sr_nxt    = insert('0, d);
            cnt_nxt   = CW'(1);
         end else begin
            case (state)
               SHIFT: begin
                  sr_nxt = insert(sr, d);
                  if (bit_count == CW'(WIDTH - 1)) begin
                     if (PARITY_EN != 0) begin
                        state_nxt = PAR;
                        cnt_nxt   = CW'(WIDTH);
                     end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        complete  = 1'b1;
                        word      = sr_nxt;
                     end
                  end else begin
                     cnt_nxt = bit_count + CW'(1);
                  end
               end
               PAR: begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  complete  = 1'b1;
                  word_perr = (PARITY_EN != 0) && (((^sr) ^ d) != (PARITY_ODD != 0));
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         sr        <= '0;
         bit_count <= '0;
      end else begin
         state     <= state_nxt;
         sr        <= sr_nxt;
         bit_count <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a              <= '0;
         a_valid        <= 1'b0;
         parity_err     <= 1'b0;
         end_conversion <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         end_conversion <= complete;
         overrun        <= 1'b0;
         if (complete) begin
            // A completed word is dropped rather than overwrite one still unconsumed.
            if (!a_valid || a_ready) begin
               a          <= word;
               a_valid    <= 1'b1;
               parity_err <= word_perr;
            end else begin
               overrun <= 1'b1;
            end
         end else if (a_valid && a_ready) begin
            a_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial2parallel_stream.sv
// Scoreboard bench: three deserialiser variants (LSB-first, MSB-first, even parity)
// share one serial stream; a monitor per instance checks each completed frame.
`timescale 1ns/1ps
module tb_serial2parallel_stream;

   typedef struct packed {
      logic [7:0] a;
      logic       perr;
      logic       ovr;
   } exp_t;

   typedef struct packed {
      logic [7:0] w;
      logic       p;
      logic [7:0] rev;
      logic       perr;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, bit_en, serial_start, d, a_ready;
   logic [7:0] a    [3];
   logic       av   [3];
   logic       eoc  [3];
   logic       perr [3];
   logic       ovr  [3];
   logic       busy [3];
   logic [3:0] bc   [3];

   int   total = 0;
   int   bad   = 0;
   exp_t q0[$], q1[$], q2[$];
   vec_t vecs [7];

   always #5 clk = ~clk;

   serial2parallel_stream #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
      .clk(clk), .reset(reset), .bit_en(bit_en), .serial_start(serial_start), .d(d),
      .a(a[0]), .a_valid(av[0]), .a_ready(a_ready), .end_conversion(eoc[0]),
      .parity_err(perr[0]), .overrun(ovr[0]), .busy(busy[0]), .bit_count(bc[0]));

   serial2parallel_stream #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
      .clk(clk), .reset(reset), .bit_en(bit_en), .serial_start(serial_start), .d(d),
      .a(a[1]), .a_valid(av[1]), .a_ready(a_ready), .end_conversion(eoc[1]),
      .parity_err(perr[1]), .overrun(ovr[1]), .busy(busy[1]), .bit_count(bc[1]));

   serial2parallel_stream #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) dut2 (
      .clk(clk), .reset(reset), .bit_en(bit_en), .serial_start(serial_start), .d(d),
      .a(a[2]), .a_valid(av[2]), .a_ready(a_ready), .end_conversion(eoc[2]),
      .parity_err(perr[2]), .overrun(ovr[2]), .busy(busy[2]), .bit_count(bc[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic mon(input int k, input logic [7:0] act_a, input logic pe, input logic ov,
                      input logic v);
      exp_t e;
      int   n;
      n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
      if (n == 0) begin
         total++;
         bad++;
         $display("FAIL dut%0d_unexpected_eoc: got a=%0h want no completion", k, act_a);
      end else begin
         case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         check($sformatf("dut%0d_a", k), 32'(act_a), 32'(e.a));
         check($sformatf("dut%0d_perr", k), 32'(pe), 32'(e.perr));
         check($sformatf("dut%0d_overrun", k), 32'(ov), 32'(e.ovr));
         check($sformatf("dut%0d_valid", k), 32'(v), 32'd1);
      end
   endtask

   for (genvar k = 0; k < 3; k++) begin : g_mon
      always @(negedge clk) if (reset && eoc[k]) mon(k, a[k], perr[k], ovr[k], av[k]);
   end

   task automatic step(input logic en, input logic st, input logic dd);
      @(negedge clk);
      bit_en       = en;
      serial_start = st;
      d            = dd;
   endtask

   // Eight data bits LSB of w first, then a parity bit; gap inserts an ignored
   // bit_en=0 cycle (with serial_start high and inverted data) before every bit.
   task automatic send_frame(input logic [7:0] w, input logic p, input bit gap,
                             input exp_t e0, input exp_t e1, input exp_t e2);
      q0.push_back(e0);
      q1.push_back(e1);
      q2.push_back(e2);
      for (int i = 0; i < 8; i++) begin
         if (gap) step(1'b0, 1'b1, ~w[i]);
         step(1'b1, logic'(i == 0), w[i]);
      end
      if (gap) begin
         step(1'b0, 1'b1, ~p);
         step(1'b1, 1'b0, p);
      end else begin
         @(negedge clk);
         check("eoc_at_last_bit", 32'(eoc[0]), 32'd1);
         check("valid_at_last_bit", 32'(av[0]), 32'd1);
         check("idle_after_frame", {busy[0], bc[0]}, 32'h0);
         check("par_state_count", {busy[2], bc[2]}, {1'b1, 4'd8});
         bit_en       = 1'b1;
         serial_start = 1'b0;
         d            = p;
      end
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_std(input vec_t v, input bit gap);
      send_frame(v.w, v.p, gap, exp_t'{v.w, 1'b0, 1'b0}, exp_t'{v.rev, 1'b0, 1'b0},
                 exp_t'{v.w, v.perr, 1'b0});
   endtask

   task automatic zero_checks(input string tag);
      check({tag, "_a"}, {8'h0, a[0], a[1], a[2]}, 32'h0);
      check({tag, "_flags"}, {av[0], av[1], av[2], eoc[0], eoc[1], eoc[2], perr[0], perr[1],
                              perr[2], ovr[0], ovr[1], ovr[2]}, 32'h0);
      check({tag, "_busy_cnt"}, {busy[0], busy[1], busy[2], bc[0], bc[1], bc[2]}, 32'h0);
   endtask

   initial begin
      vecs[0] = '{8'h4D, 1'b0, 8'hB2, 1'b0};
      vecs[1] = '{8'h4D, 1'b1, 8'hB2, 1'b1};
      vecs[2] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
      vecs[3] = '{8'hA7, 1'b1, 8'hE5, 1'b0};
      vecs[4] = '{8'h01, 1'b0, 8'h80, 1'b1};
      vecs[5] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h00, 1'b1, 8'h00, 1'b1};

      reset        = 1'b0;
      bit_en       = 1'b0;
      serial_start = 1'b0;
      d            = 1'b0;
      a_ready      = 1'b1;
      #3;
      zero_checks("reset");
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0);

      // Plain frames, consumer always ready; covers both bit orders and parity.
      for (int i = 0; i < 7; i++) send_std(vecs[i], 1'b0);

      // Consumer stalled: second frame is dropped and overrun pulses.
      a_ready = 1'b0;
      send_frame(8'h4D, 1'b0, 1'b0, exp_t'{8'h4D, 1'b0, 1'b0}, exp_t'{8'hB2, 1'b0, 1'b0},
                 exp_t'{8'h4D, 1'b0, 1'b0});
      send_frame(8'h3C, 1'b0, 1'b0, exp_t'{8'h4D, 1'b0, 1'b1}, exp_t'{8'hB2, 1'b0, 1'b1},
                 exp_t'{8'h4D, 1'b0, 1'b1});
      check("held_valid", {av[0], av[1], av[2]}, 32'h7);
      @(negedge clk);
      a_ready = 1'b1;
      @(negedge clk);
      check("drained_valid", {av[0], av[1], av[2]}, 32'h0);
      check("drained_a_held", {8'h0, a[0], a[1], a[2]}, {8'h0, 8'h4D, 8'hB2, 8'h4D});

      // Stalling strobe with a restart after four bits.
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1);
         step(1'b1, 1'b0, logic'(i[0]));
      end
      @(negedge clk);
      bit_en = 1'b0;
      check("partial_count", {busy[0], bc[0], busy[2], bc[2]}, {1'b1, 4'd4, 1'b1, 4'd4});
      send_std(vecs[3], 1'b1);

      // Async reset mid-frame with a pending word.
      a_ready = 1'b0;
      send_std(vecs[4], 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, logic'(i == 0), logic'(i[0]));
      @(negedge clk);
      bit_en = 1'b0;
      check("pre_reset_count", {bc[0], bc[2]}, {4'd5, 4'd5});
      check("pre_reset_perr", 32'(perr[2]), 32'd1);
      #2 reset = 1'b0;
      #0.5;
      zero_checks("async_reset");
      #0.5 reset = 1'b1;
      a_ready = 1'b1;
      send_std(vecs[3], 1'b0);

      step(1'b0, 1'b0, 1'b0);
      check("q0_drained", q0.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);
      check("q2_drained", q2.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
